// File: rtl/noc_run_ctrl.sv
// Run sequencer for the 3x3 NoC top: flush, enable, wait for completion or
// budget, then fold the per-node latency statistics into global min/max/sum.
module noc_run_ctrl #(
  parameter int NODE_NUM     = 9,
  parameter int TIME_SIZE    = 10,
  parameter int SUM_SIZE     = 28,
  parameter int CNT_W        = 16,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic [CNT_W-1:0]              timeout_limit,
  input  logic [NODE_NUM-1:0]           node_active,
  input  logic [NODE_NUM-1:0]           send_done,
  input  logic [NODE_NUM-1:0]           recv_done,
  input  logic [NODE_NUM*TIME_SIZE-1:0] lat_min_bus,
  input  logic [NODE_NUM*TIME_SIZE-1:0] lat_max_bus,
  input  logic [NODE_NUM*SUM_SIZE-1:0]  lat_sum_bus,
  output logic                          noc_enable,
  output logic                          noc_flush,
  output logic                          busy,
  output logic                          done,
  output logic                          timeout,
  output logic [CNT_W-1:0]              run_cycles,
  output logic [TIME_SIZE-1:0]          g_lat_min,
  output logic [TIME_SIZE-1:0]          g_lat_max,
  output logic [SUM_SIZE+3:0]           g_lat_sum
);

  localparam int IDX_W = (NODE_NUM > 1) ? $clog2(NODE_NUM) : 1;
  localparam int FC_W  = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam int GS_W  = SUM_SIZE + 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FLUSH,
    S_RUN,
    S_COLLECT,
    S_DONE
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic                 w_run_to;
  logic                 w_all_done;
  logic                 w_tmo_hit;
  logic                 w_last_idx;
  logic [FC_W-1:0]      r_flush_cnt;
  logic [CNT_W-1:0]     r_run_cycles;
  logic                 r_timeout;
  logic [IDX_W-1:0]     r_idx;
  logic [TIME_SIZE-1:0] r_acc_min;
  logic [TIME_SIZE-1:0] r_acc_max;
  logic [GS_W-1:0]      r_acc_sum;
  logic                 r_any;
  logic [TIME_SIZE-1:0] w_acc_min_nxt;
  logic [TIME_SIZE-1:0] w_acc_max_nxt;
  logic [GS_W-1:0]      w_acc_sum_nxt;
  logic                 w_any_nxt;
  logic                 w_sel_act;
  logic [TIME_SIZE-1:0] w_sel_min;
  logic [TIME_SIZE-1:0] w_sel_max;
  logic [SUM_SIZE-1:0]  w_sel_sum;
  logic [TIME_SIZE-1:0] r_g_min;
  logic [TIME_SIZE-1:0] r_g_max;
  logic [GS_W-1:0]      r_g_sum;

  assign w_all_done = &(~node_active | (send_done & recv_done));
  assign w_tmo_hit  = (timeout_limit != '0) && (r_run_cycles == timeout_limit - CNT_W'(1));
  assign w_last_idx = (r_idx == IDX_W'(NODE_NUM - 1));

  // Pick the statistics of the node currently being collected
  always_comb begin
    w_sel_act = 1'b0;
    w_sel_min = '0;
    w_sel_max = '0;
    w_sel_sum = '0;
    for (int unsigned i = 0; i < NODE_NUM; i++) begin
      if (r_idx == IDX_W'(i)) begin
        w_sel_act = node_active[i];
        w_sel_min = lat_min_bus[i*TIME_SIZE +: TIME_SIZE];
        w_sel_max = lat_max_bus[i*TIME_SIZE +: TIME_SIZE];
        w_sel_sum = lat_sum_bus[i*SUM_SIZE +: SUM_SIZE];
      end
    end
  end

  // Fold the selected node into the running min/max/sum when it is active
  always_comb begin
    w_acc_min_nxt = r_acc_min;
    w_acc_max_nxt = r_acc_max;
    w_acc_sum_nxt = r_acc_sum;
    w_any_nxt     = r_any;
    if (w_sel_act) begin
      if (w_sel_min < r_acc_min) w_acc_min_nxt = w_sel_min;
      if (w_sel_max > r_acc_max) w_acc_max_nxt = w_sel_max;
      w_acc_sum_nxt = r_acc_sum + GS_W'(w_sel_sum);
      w_any_nxt     = 1'b1;
    end
  end

  // Next-state selection and state-decoded control outputs
  always_comb begin
    w_state_nxt = r_state;
    w_run_to    = 1'b0;
    noc_enable  = 1'b0;
    noc_flush   = 1'b0;
    busy        = (r_state != S_IDLE);
    done        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) w_state_nxt = S_FLUSH;
      end
      S_FLUSH: begin
        noc_flush = 1'b1;
        if (r_flush_cnt == FC_W'(FLUSH_CYCLES - 1)) w_state_nxt = S_RUN;
      end
      S_RUN: begin
        noc_enable = 1'b1;
        // completion is only trusted from the second RUN cycle on
        if ((r_run_cycles != '0) && w_all_done) begin
          w_state_nxt = S_COLLECT;
        end else if (w_tmo_hit) begin
          w_state_nxt = S_COLLECT;
          w_run_to    = 1'b1;
        end
      end
      S_COLLECT: begin
        if (w_last_idx) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        done        = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Counters, accumulators and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_flush_cnt  <= '0;
      r_run_cycles <= '0;
      r_timeout    <= 1'b0;
      r_idx        <= '0;
      r_acc_min    <= '0;
      r_acc_max    <= '0;
      r_acc_sum    <= '0;
      r_any        <= 1'b0;
      r_g_min      <= '0;
      r_g_max      <= '0;
      r_g_sum      <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_flush_cnt  <= '0;
            r_run_cycles <= '0;
            r_timeout    <= 1'b0;
          end
        end
        S_FLUSH: r_flush_cnt <= r_flush_cnt + FC_W'(1);
        S_RUN: begin
          if (r_run_cycles != '1) r_run_cycles <= r_run_cycles + CNT_W'(1);
          if (w_run_to) r_timeout <= 1'b1;
          if (w_state_nxt == S_COLLECT) begin
            r_acc_min <= '1;
            r_acc_max <= '0;
            r_acc_sum <= '0;
            r_idx     <= '0;
            r_any     <= 1'b0;
          end
        end
        S_COLLECT: begin
          r_acc_min <= w_acc_min_nxt;
          r_acc_max <= w_acc_max_nxt;
          r_acc_sum <= w_acc_sum_nxt;
          r_any     <= w_any_nxt;
          r_idx     <= r_idx + IDX_W'(1);
          // results are latched on entry to DONE so they are valid while done is high
          if (w_last_idx) begin
            r_g_min <= w_any_nxt ? w_acc_min_nxt : '0;
            r_g_max <= w_acc_max_nxt;
            r_g_sum <= w_acc_sum_nxt;
          end
        end
        default: ;
      endcase
    end
  end

  assign timeout    = r_timeout;
  assign run_cycles = r_run_cycles;
  assign g_lat_min  = r_g_min;
  assign g_lat_max  = r_g_max;
  assign g_lat_sum  = r_g_sum;

endmodule

// File: tb/tb_noc_run_ctrl.sv
// Self-checking bench for noc_run_ctrl: scenario tasks against a behavioural model.
module tb_noc_run_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] timeout_limit = '0;
  logic [8:0]  node_active = '0;
  logic [8:0]  send_done = '0;
  logic [8:0]  recv_done = '0;
  logic [89:0] lat_min_bus;
  logic [89:0] lat_max_bus;
  logic [251:0] lat_sum_bus;
  logic        noc_enable, noc_flush, busy, done, timeout;
  logic [15:0] run_cycles;
  logic [9:0]  g_lat_min, g_lat_max;
  logic [31:0] g_lat_sum;

  logic [9:0]  m_min [9];
  logic [9:0]  m_max [9];
  logic [27:0] m_sum [9];

  int n_checks = 0;
  int n_fail = 0;

  // observations from the last run
  int o_flush, o_run, o_coll, o_done, o_first_run, o_overlap;
  bit o_seen, o_busy_after;
  logic [15:0] o_rc;
  logic        o_to;
  logic [9:0]  o_min, o_max;
  logic [31:0] o_sum;

  // model expectations
  logic [15:0] e_rc;
  logic        e_to;
  logic [9:0]  e_min, e_max;
  logic [31:0] e_sum;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 9; g++) begin : g_pack
    assign lat_min_bus[g*10 +: 10] = m_min[g];
    assign lat_max_bus[g*10 +: 10] = m_max[g];
    assign lat_sum_bus[g*28 +: 28] = m_sum[g];
  end

  noc_run_ctrl #(
    .NODE_NUM(9), .TIME_SIZE(10), .SUM_SIZE(28), .CNT_W(16), .FLUSH_CYCLES(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .timeout_limit(timeout_limit),
    .node_active(node_active), .send_done(send_done), .recv_done(recv_done),
    .lat_min_bus(lat_min_bus), .lat_max_bus(lat_max_bus), .lat_sum_bus(lat_sum_bus),
    .noc_enable(noc_enable), .noc_flush(noc_flush), .busy(busy), .done(done),
    .timeout(timeout), .run_cycles(run_cycles), .g_lat_min(g_lat_min),
    .g_lat_max(g_lat_max), .g_lat_sum(g_lat_sum)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic rand_lat;
    for (int i = 0; i < 9; i++) begin
      m_min[i] = 10'($urandom_range(0, 1023));
      m_max[i] = 10'($urandom_range(0, 1023));
      m_sum[i] = 28'($urandom);
    end
  endtask

  // Expected outcome from the run rules: which RUN cycle ends the run and why,
  // and the min/max/sum over active nodes.
  task automatic model(input logic [8:0] act, input logic [8:0] never,
                       input logic [15:0] lim, input int fin, input bit stale);
    logic [8:0] fl;
    int mn, mx;
    longint s;
    e_rc = '0;
    e_to = 1'b0;
    for (int k = 0; k < 5000; k++) begin
      fl = (stale || (fin >= 0 && k >= fin)) ? ~never : 9'h0;
      if (k >= 1 && ((~act | fl) == 9'h1FF)) begin
        e_rc = 16'(k + 1);
        e_to = 1'b0;
        break;
      end
      if (lim != 0 && k == int'(lim) - 1) begin
        e_rc = 16'(k + 1);
        e_to = 1'b1;
        break;
      end
    end
    mn = 1024; mx = 0; s = 0;
    for (int i = 0; i < 9; i++) begin
      if (act[i]) begin
        if (int'(m_min[i]) < mn) mn = int'(m_min[i]);
        if (int'(m_max[i]) > mx) mx = int'(m_max[i]);
        s += longint'(m_sum[i]);
      end
    end
    e_min = (mn == 1024) ? 10'd0 : 10'(mn);
    e_max = 10'(mx);
    e_sum = 32'(s);
  endtask

  // Drive one run from a start pulse and record what the DUT does; returns at
  // the cycle after done so a caller can issue a start right then.
  task automatic run_and_observe(input logic [8:0] act, input logic [8:0] never,
                                 input logic [15:0] lim, input int fin,
                                 input bit stale, input bit extra_start);
    int cyc, k;
    node_active   = act;
    timeout_limit = lim;
    send_done     = stale ? ~never : 9'h0;
    recv_done     = send_done;
    o_flush = 0; o_run = 0; o_coll = 0; o_done = 0; o_first_run = 0; o_overlap = 0;
    o_seen = 1'b0; o_busy_after = 1'b1;
    o_rc = '0; o_to = 1'b0; o_min = '0; o_max = '0; o_sum = '0;
    start = 1'b1;
    cyc = 0;
    while (!o_seen && cyc < 3000) begin
      tick;
      cyc++;
      start = 1'b0;
      if (noc_flush) o_flush++;
      if (noc_flush && noc_enable) o_overlap++;
      if (noc_enable) begin
        k = o_run;
        if (o_first_run == 0) o_first_run = cyc;
        o_run++;
        send_done = (stale || (fin >= 0 && k >= fin)) ? ~never : 9'h0;
        recv_done = send_done;
        if (extra_start && k == 3) start = 1'b1;
      end else if (done) begin
        o_done++;
        o_seen = 1'b1;
        o_rc = run_cycles; o_to = timeout;
        o_min = g_lat_min; o_max = g_lat_max; o_sum = g_lat_sum;
        start = extra_start;
      end else if (busy && !noc_flush && o_run > 0) begin
        o_coll++;
      end
    end
    if (o_seen) begin
      tick;
      start = 1'b0;
      o_busy_after = busy;
      if (done) o_done++;
    end
  endtask

  task automatic chk_run(input string name);
    n_checks++;
    if (!o_seen || o_flush != 2 || o_first_run != 3 || o_run != int'(e_rc) ||
        o_coll != 9 || o_done != 1 || o_overlap != 0 || o_busy_after) begin
      n_fail++;
      $display("FAIL %s_timing: seen=%0d flush=%0d first_run=%0d run=%0d collect=%0d done_pulses=%0d overlap=%0d busy_after=%0d, required 1/2/3/%0d/9/1/0/0",
               name, o_seen, o_flush, o_first_run, o_run, o_coll, o_done, o_overlap, o_busy_after, e_rc);
    end
    n_checks++;
    if ({o_to, o_rc, o_min, o_max, o_sum} !== {e_to, e_rc, e_min, e_max, e_sum}) begin
      n_fail++;
      $display("FAIL %s_result: got to=%0d rc=%0d min=%0d max=%0d sum=%0d, required to=%0d rc=%0d min=%0d max=%0d sum=%0d",
               name, o_to, o_rc, o_min, o_max, o_sum, e_to, e_rc, e_min, e_max, e_sum);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({noc_enable, noc_flush, busy, done, timeout, run_cycles, g_lat_min, g_lat_max, g_lat_sum} !== '0) begin
      n_fail++;
      $display("FAIL reset_state: en=%0d fl=%0d busy=%0d done=%0d to=%0d rc=%0d min=%0d max=%0d sum=%0d, required all 0",
               noc_enable, noc_flush, busy, done, timeout, run_cycles, g_lat_min, g_lat_max, g_lat_sum);
    end
    tick;
    rst_n = 1'b1;
    tick;
  endtask

  task automatic test_basic;
    for (int i = 0; i < 9; i++) begin
      m_min[i] = (i == 4) ? 10'd1 : 10'd3;
      m_max[i] = (i == 1) ? 10'd9 : ((i == 4) ? 10'd12 : 10'd7);
      m_sum[i] = 28'd10;
    end
    model(9'h1EF, 9'h0, 16'd0, 5, 1'b0);
    run_and_observe(9'h1EF, 9'h0, 16'd0, 5, 1'b0, 1'b0);
    chk_run("basic");
    n_checks++;
    if ({o_min, o_max, o_sum, o_to, o_rc} !== {10'd3, 10'd9, 32'd80, 1'b0, 16'd6}) begin
      n_fail++;
      $display("FAIL basic_const: got min=%0d max=%0d sum=%0d to=%0d rc=%0d, required 3/9/80/0/6",
               o_min, o_max, o_sum, o_to, o_rc);
    end
  endtask

  task automatic test_timeout;
    rand_lat();
    model(9'h1EF, 9'h100, 16'd20, 5, 1'b0);
    run_and_observe(9'h1EF, 9'h100, 16'd20, 5, 1'b0, 1'b0);
    chk_run("timeout");
    n_checks++;
    if (o_run != 20 || o_rc !== 16'd20 || o_to !== 1'b1) begin
      n_fail++;
      $display("FAIL timeout_const: got run=%0d rc=%0d to=%0d, required 20/20/1", o_run, o_rc, o_to);
    end
  endtask

  task automatic test_tie;
    rand_lat();
    model(9'h0FF, 9'h0, 16'd8, 7, 1'b0);
    run_and_observe(9'h0FF, 9'h0, 16'd8, 7, 1'b0, 1'b0);
    chk_run("tie");
    n_checks++;
    if (o_rc !== 16'd8 || o_to !== 1'b0) begin
      n_fail++;
      $display("FAIL tie_const: got rc=%0d to=%0d, required 8/0", o_rc, o_to);
    end
  endtask

  task automatic test_stale_flags;
    rand_lat();
    model(9'h1EF, 9'h0, 16'd0, -1, 1'b1);
    run_and_observe(9'h1EF, 9'h0, 16'd0, -1, 1'b1, 1'b0);
    chk_run("stale");
    n_checks++;
    if (o_rc < 16'd2) begin
      n_fail++;
      $display("FAIL stale_min_run: got rc=%0d, required >=2", o_rc);
    end
    send_done = '0;
    recv_done = '0;
  endtask

  task automatic test_none_active;
    rand_lat();
    model(9'h0, 9'h0, 16'd0, -1, 1'b0);
    run_and_observe(9'h0, 9'h0, 16'd0, -1, 1'b0, 1'b0);
    chk_run("none");
    n_checks++;
    if ({o_rc, o_min, o_max, o_sum} !== {16'd2, 10'd0, 10'd0, 32'd0}) begin
      n_fail++;
      $display("FAIL none_const: got rc=%0d min=%0d max=%0d sum=%0d, required 2/0/0/0",
               o_rc, o_min, o_max, o_sum);
    end
  endtask

  task automatic test_back_to_back;
    rand_lat();
    model(9'h1FF, 9'h0, 16'd0, 6, 1'b0);
    run_and_observe(9'h1FF, 9'h0, 16'd0, 6, 1'b0, 1'b1);
    chk_run("extra_start");
    rand_lat();
    model(9'h15A, 9'h0, 16'd0, 3, 1'b0);
    run_and_observe(9'h15A, 9'h0, 16'd0, 3, 1'b0, 1'b0);
    chk_run("b2b_second");
  endtask

  task automatic test_reset_mid_run;
    int k, guard, cnt;
    rand_lat();
    node_active = 9'h1FF; timeout_limit = '0; send_done = '0; recv_done = '0;
    start = 1'b1;
    tick;
    start = 1'b0;
    k = 0; guard = 0;
    while (k < 4 && guard < 50) begin
      tick;
      guard++;
      if (noc_enable) k++;
    end
    n_checks++;
    if (noc_enable !== 1'b1) begin
      n_fail++;
      $display("FAIL midrun_reached: got en=%0d after %0d cycles, required 1", noc_enable, guard);
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({noc_enable, noc_flush, busy, done, timeout, run_cycles} !== '0) begin
      n_fail++;
      $display("FAIL async_reset: got en=%0d fl=%0d busy=%0d done=%0d to=%0d rc=%0d, required all 0",
               noc_enable, noc_flush, busy, done, timeout, run_cycles);
    end
    send_done = '1; recv_done = '1;
    repeat (2) tick;
    rst_n = 1'b1;
    cnt = 0;
    repeat (15) begin
      tick;
      if (done || busy) cnt++;
    end
    n_checks++;
    if (cnt != 0) begin
      n_fail++;
      $display("FAIL post_reset_idle: got %0d busy/done cycles, required 0", cnt);
    end
    send_done = '0; recv_done = '0;
    model(9'h1FF, 9'h0, 16'd0, 4, 1'b0);
    run_and_observe(9'h1FF, 9'h0, 16'd0, 4, 1'b0, 1'b0);
    chk_run("after_reset");
  endtask

  task automatic test_random;
    logic [8:0]  act, never;
    logic [15:0] lim;
    int fin;
    for (int it = 0; it < 5; it++) begin
      rand_lat();
      act   = 9'($urandom_range(0, 511));
      lim   = ($urandom_range(0, 2) == 0) ? 16'd0 : 16'($urandom_range(1, 30));
      fin   = int'($urandom_range(0, 25));
      never = (lim != 0 && $urandom_range(0, 1) == 1) ? 9'($urandom_range(1, 511)) : 9'h0;
      model(act, never, lim, fin, 1'b0);
      run_and_observe(act, never, lim, fin, 1'b0, 1'b0);
      chk_run("random");
    end
  endtask

  initial begin
    for (int i = 0; i < 9; i++) begin
      m_min[i] = '0; m_max[i] = '0; m_sum[i] = '0;
    end
    test_reset();
    test_basic();
    test_timeout();
    test_tie();
    test_stale_flags();
    test_none_active();
    test_back_to_back();
    test_reset_mid_run();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
